// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundles the FIFO read port and the downstream valid/ready stream of the
// read-side adapter. The adapter takes the slave view; the environment that
// holds the FIFO and the consumer takes the master view.
interface fifo_rd_stream_adapter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
);
   logic                  FIFO_EMPTY;
   logic [DATA_WIDTH-1:0] FIFO_DATA;
   logic                  FIFO_RD_EN;
   logic                  OUT_VALID;
   logic                  OUT_READY;
   logic [DATA_WIDTH-1:0] OUT_DATA;
   logic                  BUSY;
   logic [CNT_WIDTH-1:0]  XFER_CNT;

   modport slave (
      input  FIFO_EMPTY, FIFO_DATA, OUT_READY,
      output FIFO_RD_EN, OUT_VALID, OUT_DATA, BUSY, XFER_CNT
   );

   modport master (
      output FIFO_EMPTY, FIFO_DATA, OUT_READY,
      input  FIFO_RD_EN, OUT_VALID, OUT_DATA, BUSY, XFER_CNT
   );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter for simple_linear_fifo: issues RD_EN on credit, captures
// the registered FIFO output one cycle later into a 2-entry buffer and
// presents the head word on a valid/ready stream. Credit counts buffered
// words plus the read in flight, so the buffer can never overflow.
module fifo_rd_stream_adapter #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                     FCLK,
   input  logic                     FRSTN,
   fifo_rd_stream_adapter_if.slave  bus
);

   logic [1:0]            r_occ;
   logic                  r_inflight;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   logic [CNT_WIDTH-1:0]  r_xfer_cnt;

   logic                  w_pop;
   logic                  w_rd_en;
   logic [2:0]            w_credit_used;
   logic [1:0]            w_occ_after_pop;

   // Handshake and read credit. The OUT_READY -> FIFO_RD_EN path is
   // combinational on purpose: a word leaving this cycle frees a slot for a
   // read issued in the same cycle, which keeps one word per clock.
   always_comb begin
      w_pop           = (r_occ != 2'd0) & bus.OUT_READY;
      w_occ_after_pop = r_occ - {1'b0, w_pop};
      w_credit_used   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
      w_rd_en         = FRSTN & ~bus.FIFO_EMPTY & (w_credit_used < 3'd2);
   end

   // Occupancy and in-flight tracking; a read in flight is dropped on reset.
   always_ff @(posedge FCLK or negedge FRSTN) begin
      if (!FRSTN) begin
         r_occ      <= 2'd0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      end
   end

   // Buffer entries: a pop shifts tail into head, and a captured word lands
   // in whichever slot is first free after that pop.
   always_ff @(posedge FCLK or negedge FRSTN) begin
      if (!FRSTN) begin
         r_head <= '0;
         r_tail <= '0;
      end else begin
         if (w_pop && (r_occ == 2'd2)) begin
            r_head <= r_tail;
         end
         if (r_inflight) begin
            if (w_occ_after_pop == 2'd0) begin
               r_head <= bus.FIFO_DATA;
            end else begin
               r_tail <= bus.FIFO_DATA;
            end
         end
      end
   end

   // Delivered-word counter, wraps naturally at 2^CNT_WIDTH.
   always_ff @(posedge FCLK or negedge FRSTN) begin
      if (!FRSTN) begin
         r_xfer_cnt <= '0;
      end else if (w_pop) begin
         r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
   end

   assign bus.FIFO_RD_EN = w_rd_en;
   assign bus.OUT_VALID  = (r_occ != 2'd0);
   assign bus.OUT_DATA   = r_head;
   assign bus.BUSY       = (r_occ != 2'd0) | r_inflight;
   assign bus.XFER_CNT   = r_xfer_cnt;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: a behavioural FIFO feeds two adapters
// (16-bit and 4-bit transfer counters) from the same stimulus; a scoreboard
// queue holds every word written and is popped on each output handshake.
module tb_fifo_rd_stream_adapter;

   logic       FCLK;
   logic       frstn;
   logic       out_ready;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       fifo_empty;
   logic [7:0] fifo_data;

   fifo_rd_stream_adapter_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) if_a ();
   fifo_rd_stream_adapter_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  if_b ();

   assign if_a.FIFO_EMPTY = fifo_empty;
   assign if_a.FIFO_DATA  = fifo_data;
   assign if_a.OUT_READY  = out_ready;
   assign if_b.FIFO_EMPTY = fifo_empty;
   assign if_b.FIFO_DATA  = fifo_data;
   assign if_b.OUT_READY  = out_ready;

   fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut_a (
      .FCLK  (FCLK),
      .FRSTN (frstn),
      .bus   (if_a)
   );

   fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut_b (
      .FCLK  (FCLK),
      .FRSTN (frstn),
      .bus   (if_b)
   );

   initial FCLK = 1'b0;
   always #5 FCLK = ~FCLK;

   // Behavioural FIFO: registered DATA_OUT, one write per clock, cleared by reset.
   logic [7:0] fq[$];
   always @(posedge FCLK or negedge frstn) begin
      if (!frstn) begin
         fq.delete();
         fifo_empty <= 1'b1;
         fifo_data  <= 8'h00;
      end else begin
         if (if_a.FIFO_RD_EN && (fq.size() != 0)) begin
            fifo_data <= fq[0];
            fq.delete(0);
         end
         if (wr_en) fq.push_back(wr_data);
         fifo_empty <= (fq.size() == 0);
      end
   end

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   int reads = 0;
   int pops  = 0;
   int cyc   = 0;
   int rd_first, rd_last, pop_first, pop_last;
   bit hold_v = 1'b0;
   logic [7:0] hold_d = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic clear_marks();
      rd_first  = -1;
      rd_last   = -1;
      pop_first = -1;
      pop_last  = -1;
   endtask

   // One clock of monitoring: sample at the falling edge, return at posedge+1.
   task automatic tick();
      @(negedge FCLK);
      cyc++;
      chk("rd_while_empty", {31'd0, if_a.FIFO_RD_EN & fifo_empty}, 32'd0);
      chk("outstanding_le2", {31'd0, (reads - pops) <= 2}, 32'd1);
      chk("busy", {31'd0, if_a.BUSY}, {31'd0, (reads - pops) != 0});
      chk("xfer_a", {16'd0, if_a.XFER_CNT}, {16'd0, pops[15:0]});
      chk("xfer_b", {28'd0, if_b.XFER_CNT}, {28'd0, pops[3:0]});
      if (hold_v) begin
         chk("hold_valid", {31'd0, if_a.OUT_VALID}, 32'd1);
         chk("hold_data", {24'd0, if_a.OUT_DATA}, {24'd0, hold_d});
      end
      if (if_a.OUT_VALID && out_ready) begin
         if (exp_q.size() == 0) chk("extra_word", {31'd0, if_a.OUT_VALID}, 32'd0);
         else chk("data", {24'd0, if_a.OUT_DATA}, {24'd0, exp_q.pop_front()});
         pops++;
         if (pop_first < 0) pop_first = cyc;
         pop_last = cyc;
      end
      hold_v = if_a.OUT_VALID && !out_ready;
      hold_d = if_a.OUT_DATA;
      if (if_a.FIFO_RD_EN && !fifo_empty) begin
         reads++;
         if (rd_first < 0) rd_first = cyc;
         rd_last = cyc;
      end
      @(posedge FCLK);
      #1;
   endtask

   task automatic write_words(input logic [7:0] first, input logic [7:0] step,
                              input int n, input bit toggle);
      logic [7:0] d;
      d = first;
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = d;
         exp_q.push_back(d);
         if (toggle) out_ready = ~out_ready;
         tick();
         d = d + step;
      end
      wr_en = 1'b0;
   endtask

   task automatic drain(input string tag, input bit toggle, input int budget);
      for (int i = 0; i < budget; i++) begin
         if ((exp_q.size() == 0) && (reads == pops)) break;
         if (toggle) out_ready = ~out_ready;
         tick();
      end
      chk(tag, exp_q.size(), 32'd0);
      out_ready = 1'b1;
      repeat (2) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, {31'd0, if_a.FIFO_RD_EN}, 32'd0);
      chk({tag, "_valid"}, {31'd0, if_a.OUT_VALID}, 32'd0);
      chk({tag, "_busy"},  {31'd0, if_a.BUSY}, 32'd0);
      chk({tag, "_xfer"},  {16'd0, if_a.XFER_CNT}, 32'd0);
      chk({tag, "_data"},  {24'd0, if_a.OUT_DATA}, 32'd0);
      chk({tag, "_xfer_b"}, {28'd0, if_b.XFER_CNT}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base_r, base_p;
      frstn     = 1'b0;
      out_ready = 1'b0;
      wr_en     = 1'b0;
      wr_data   = 8'h00;
      clear_marks();

      // Reset and idle.
      repeat (3) @(posedge FCLK);
      #1;
      check_reset_outputs("rst");
      frstn = 1'b1;
      repeat (10) tick();
      check_reset_outputs("idle");

      // Three words with an always-ready consumer.
      out_ready = 1'b1;
      clear_marks();
      write_words(8'h11, 8'h11, 3, 1'b0);
      drain("t2_drain", 1'b0, 20);
      chk("t2_reads", reads, 32'd3);
      chk("t2_rd_span", rd_last - rd_first, 32'd2);
      chk("t2_latency", pop_first - rd_first, 32'd2);
      chk("t2_pop_span", pop_last - pop_first, 32'd2);
      chk("t2_xfer", {16'd0, if_a.XFER_CNT}, 32'd3);

      // Backpressure: only two reads while the consumer stalls.
      out_ready = 1'b0;
      base_r = reads;
      base_p = pops;
      write_words(8'h01, 8'h01, 8, 1'b0);
      repeat (4) tick();
      chk("t3_reads", reads - base_r, 32'd2);
      chk("t3_rd_en_low", {31'd0, if_a.FIFO_RD_EN}, 32'd0);
      chk("t3_head", {24'd0, if_a.OUT_DATA}, 32'h01);
      chk("t3_valid", {31'd0, if_a.OUT_VALID}, 32'd1);
      out_ready = 1'b1;
      clear_marks();
      drain("t3_drain", 1'b0, 40);
      chk("t3_pops", pops - base_p, 32'd8);
      chk("t3_pop_span", pop_last - pop_first, 32'd7);

      // Consumer toggling every cycle.
      base_p = pops;
      out_ready = 1'b0;
      write_words(8'h00, 8'h01, 16, 1'b1);
      drain("t4_drain", 1'b1, 80);
      chk("t4_pops", pops - base_p, 32'd16);

      // Asynchronous reset while the buffer is full and the FIFO still holds data.
      out_ready = 1'b0;
      write_words(8'h71, 8'h01, 3, 1'b0);
      repeat (3) tick();
      chk("t5_pre_outstanding", reads - pops, 32'd2);
      chk("t5_pre_busy", {31'd0, if_a.BUSY}, 32'd1);
      frstn = 1'b0;
      #1;
      check_reset_outputs("t5_async");
      #4;
      frstn = 1'b1;
      exp_q.delete();
      reads  = 0;
      pops   = 0;
      hold_v = 1'b0;
      @(posedge FCLK);
      #1;
      out_ready = 1'b1;
      write_words(8'hA5, 8'h00, 1, 1'b0);
      drain("t5_drain", 1'b0, 20);
      chk("t5_xfer", {16'd0, if_a.XFER_CNT}, 32'd1);

      // 16 more words: 17 since reset, the 4-bit counter wraps to 1.
      write_words(8'h40, 8'h03, 16, 1'b0);
      drain("t6_drain", 1'b0, 40);
      chk("t6_xfer_a", {16'd0, if_a.XFER_CNT}, 32'd17);
      chk("t6_xfer_b", {28'd0, if_b.XFER_CNT}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
